// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5..DBIT_MAX data bits, 1/1.5/2 stop bits, optional parity)
//
// Optional feature macro: UART_TX_PARITY_EN adds port i_parity, the PARITY state and parity generation.
//
// Ports:
//   i_clk           clock, all state on rising edge
//   i_reset_n       synchronous active-low reset
//   i_s_tick        baud enable, OVERSAMPLE pulses per bit
//   i_tx_start      frame request (pulse or level), honoured only in IDLE
//   i_data          payload, LSB first
//   i_dbits         data-bit count, clamped to 5..DBIT_MAX
//   i_stop_cfg      stop length: 00=1, 01=1.5, 1x=2 bits
//   i_parity        00/11=none, 01=even, 10=odd (UART_TX_PARITY_EN only)
//   o_tx            registered serial line, idle high
//   o_busy          high while a frame is in progress, including the done cycle
//   o_tx_done_tick  one-cycle pulse on the final stop tick
module uart_tx_cfg #(
    parameter int DBIT_MAX   = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_s_tick,
    input  logic                i_tx_start,
    input  logic [DBIT_MAX-1:0] i_data,
    input  logic [3:0]          i_dbits,
    input  logic [1:0]          i_stop_cfg,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]          i_parity,
`endif
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_tx_done_tick
);
    localparam int CW = $clog2(2 * OVERSAMPLE);
    localparam logic [CW-1:0] T_1  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] T_15 = CW'(3 * OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_2  = CW'(2 * OVERSAMPLE - 1);
    localparam logic [3:0]    DMAX = 4'(DBIT_MAX);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [3:0]          nbits_q, nbits_d;
    logic [DBIT_MAX-1:0] sh_q, sh_d;
    logic [1:0]          stop_q, stop_d;
    logic                tx_q, tx_d;
    logic                tick_end, done;
    logic [CW-1:0]       last;
`ifdef UART_TX_PARITY_EN
    logic [1:0]          mode_q, mode_d;
    logic                par_q, par_d;
`endif

    // Last tick index of the current state; STOP length comes from the latched config.
    assign last     = (state_q != STOP) ? T_1 : (stop_q == 2'b00) ? T_1 : (stop_q == 2'b01) ? T_15 : T_2;
    assign tick_end = i_s_tick && (tick_q == last);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        sh_d    = sh_q;
        stop_d  = stop_q;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        mode_d  = mode_q;
        par_d   = par_q;
`endif
        if (i_s_tick && state_q != IDLE)
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        case (state_q)
            IDLE: if (i_tx_start) begin
                sh_d    = i_data;
                nbits_d = (i_dbits < 4'd5) ? 4'd5 : (i_dbits > DMAX) ? DMAX : i_dbits;
                stop_d  = i_stop_cfg;
                tick_d  = '0;
                bit_d   = '0;
                state_d = START;
`ifdef UART_TX_PARITY_EN
                mode_d  = i_parity;
                // Seeding with 1 for odd mode makes the running XOR the odd parity bit directly.
                par_d   = (i_parity == 2'b10);
`endif
            end
            START: if (tick_end) state_d = DATA;
            DATA: if (tick_end) begin
                sh_d  = sh_q >> 1;
                bit_d = bit_q + 4'd1;
`ifdef UART_TX_PARITY_EN
                par_d = par_q ^ sh_q[0];
                if (bit_q == nbits_q - 4'd1) state_d = (^mode_q) ? PARITY : STOP;
`else
                if (bit_q == nbits_q - 4'd1) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick_end) state_d = STOP;
`endif
            STOP: if (tick_end) begin
                done    = i_reset_n;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_TX_PARITY_EN
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : (state_d == PARITY) ? par_d : 1'b1;
`else
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            sh_q    <= '0;
            stop_q  <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            mode_q  <= '0;
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            sh_q    <= sh_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            mode_q  <= mode_d;
            par_q   <= par_d;
`endif
        end
    end

    assign o_tx           = tx_q;
    assign o_busy         = (state_q != IDLE);
    assign o_tx_done_tick = done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg; stimulus queues expected frames, a monitor checks each frame
module tb_uart_tx_cfg;
    localparam int OS = 16;

    typedef struct {
        logic [15:0] lvl;
        int          nb;
        int          total;
        bit          abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       start = 1'b0;
    logic [8:0] data = '0;
    logic [3:0] dbits = 4'd8;
    logic [1:0] stop_cfg = '0;
    logic [1:0] parity = '0;
    logic       tx, busy, done;

    int   checks = 0;
    int   errors = 0;
    int   div = 1;
    int   tcnt = 0;
    exp_t exp_q[$];

    uart_tx_cfg #(.DBIT_MAX(9), .OVERSAMPLE(OS)) dut (
        .i_clk(clk),
        .i_reset_n(reset_n),
        .i_s_tick(s_tick),
        .i_tx_start(start),
        .i_data(data),
        .i_dbits(dbits),
        .i_stop_cfg(stop_cfg),
`ifdef UART_TX_PARITY_EN
        .i_parity(parity),
`endif
        .o_tx(tx),
        .o_busy(busy),
        .o_tx_done_tick(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        tcnt   = (tcnt + 1 >= div) ? 0 : tcnt + 1;
        s_tick = (tcnt == 0);
    end

    function automatic logic [255:0] expand(input exp_t e);
        logic [255:0] m = '0;
        for (int k = 0; k < e.total && k < 256; k++)
            m[k] = (k < e.nb * OS) ? e.lvl[k / OS] : 1'b1;
        return m;
    endfunction

    // Monitor: records o_tx on every tick of a frame and scores it at done or at abort.
    exp_t         cur;
    bit           active = 0, post_done = 0, stable_ok = 1;
    logic         prev_busy = 0, prev_tick = 0, prev_tx = 1;
    int           ticks = 0;
    logic [255:0] got = '0;
    always @(negedge clk) begin
        if (post_done) begin
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_done: tx=%b busy=%b, want tx=1 busy=0", tx, busy);
            end
            post_done = 0;
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: frame started with nothing queued, want no frame");
            end else begin
                cur = exp_q.pop_front();
                active = 1; ticks = 0; got = '0; stable_ok = 1;
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL start_level: tx=%b at acceptance, want 0", tx);
                end
            end
        end
        if (active && busy === 1'b1) begin
            if (prev_busy === 1'b1 && prev_tick !== 1'b1 && tx !== prev_tx) stable_ok = 0;
            if (s_tick) begin
                if (ticks < 256) got[ticks] = tx;
                ticks++;
            end
            if (done === 1'b1) begin
                checks += 4;
                if (cur.abort) begin
                    errors++;
                    $display("FAIL abort_flag: done pulsed, want abort without done");
                end
                if (ticks != cur.total) begin
                    errors++;
                    $display("FAIL done_tick: done at tick %0d, want %0d", ticks, cur.total);
                end
                if (got !== expand(cur)) begin
                    errors++;
                    $display("FAIL waveform: got %h want %h", got, expand(cur));
                end
                if (!stable_ok) begin
                    errors++;
                    $display("FAIL stable: tx changed between ticks, want stable");
                end
                active = 0;
                post_done = 1;
            end
        end else if (active) begin
            checks += 2;
            if (!cur.abort) begin
                errors++;
                $display("FAIL abort_flag: frame ended without done at tick %0d, want done at %0d", ticks, cur.total);
            end
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL abort_tx: tx=%b after abort, want 1", tx);
            end
            active = 0;
        end else if (done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL stray_done: done=1 with no frame active, want 0");
        end
        prev_busy = busy;
        prev_tick = s_tick;
        prev_tx   = tx;
    end

    task automatic send(input logic [8:0] d, input logic [3:0] nb, input logic [1:0] st, input logic [1:0] par, input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        data = d; dbits = nb; stop_cfg = st; parity = par; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; data = ~d; dbits = ~nb; stop_cfg = ~st; parity = ~par;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy === 1'b1 && n < 5000);
        if (busy === 1'b1) begin
            errors++;
            $display("FAIL timeout: busy still %b after %0d cycles, want 0", busy, n);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks += 3;
        if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: %b want 0", done); end

        send(9'h0A5, 4'd8, 2'b00, 2'b00, '{16'h014A, 9, 160, 1'b0});
        wait_idle();
`ifdef UART_TX_PARITY_EN
        send(9'h041, 4'd7, 2'b10, 2'b01, '{16'h0082, 9, 176, 1'b0});
        wait_idle();
        send(9'h0FF, 4'd5, 2'b00, 2'b10, '{16'h003E, 7, 128, 1'b0});
        wait_idle();
`else
        send(9'h041, 4'd7, 2'b10, 2'b01, '{16'h0082, 8, 160, 1'b0});
        wait_idle();
`endif
        send(9'h01F, 4'd3, 2'b01, 2'b00, '{16'h003E, 6, 120, 1'b0});
        wait_idle();
        send(9'h1A5, 4'd15, 2'b00, 2'b00, '{16'h034A, 10, 176, 1'b0});
        wait_idle();

        send(9'h03C, 4'd8, 2'b00, 2'b00, '{16'h0078, 9, 160, 1'b0});
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done !== 1'b1 && n < 5000);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL done_wait: done=%b after %0d cycles, want 1", done, n);
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);

        send(9'h000, 4'd8, 2'b00, 2'b00, '{16'h0000, 9, 160, 1'b1});
        repeat (72) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);

        div = 3;
        repeat (6) @(posedge clk);
        send(9'h05A, 4'd8, 2'b00, 2'b00, '{16'h00B4, 9, 160, 1'b0});
        wait_idle();
        repeat (20) @(posedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d frames never seen, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
